// File: rtl/frame_load_ctrl.sv
// frame_load_ctrl
//   Sequences SPI-received pixel bytes into a double-buffered frame RAM. Bytes are always
//   written to the buffer the scanner is not reading. A completed frame is handed to the
//   scanner only at its end-of-frame boundary, so a displayed frame never tears.
//
// Ports
//   CLK             system clock
//   RST             synchronous, active-high reset
//   cs_n            SPI chip select (already synchronised), low = transfer active
//   rx_valid        one-cycle strobe, rx_data holds a new byte
//   rx_data         received byte
//   disp_frame_end  one-cycle pulse from the scanner after the last row of a scan
//   wr_en           frame RAM write enable (registered)
//   wr_addr         {buffer select, byte index} (registered)
//   wr_data         frame RAM write data (registered)
//   disp_buf        buffer the scanner reads, 0 = a, 1 = b
//   load_busy       high whenever a transfer is being loaded or a swap is pending
//   frame_ready     full frame loaded, swap pending
//   short_err       one-cycle pulse: transfer ended before a full frame
//   overrun_err     one-cycle pulse: byte received while a swap is pending
//   frame_count     number of completed swaps, wraps at 256
module frame_load_ctrl #(
    parameter int unsigned COLS   = 64,
    parameter int unsigned ROWS   = 32,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cs_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              disp_frame_end,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [7:0]        wr_data,
    output logic              disp_buf,
    output logic              load_busy,
    output logic              frame_ready,
    output logic              short_err,
    output logic              overrun_err,
    output logic [7:0]        frame_count
);

    localparam int unsigned FRAME_BYTES = COLS * ROWS * 3;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPend
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              disp_buf_q, disp_buf_d;
    logic              short_err_q, short_err_d;
    logic              overrun_err_q, overrun_err_d;
    logic [7:0]        frame_count_q, frame_count_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        disp_buf_d    = disp_buf_q;
        short_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        frame_count_d = frame_count_q;

        unique case (state_q)
            StIdle: begin
                // Bytes strobed while idle are ignored; the next transfer starts at index 0.
                idx_d = '0;
                if (!cs_n) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (cs_n) begin
                    // Transfer ended early: drop any byte in this cycle, keep displayed buffer.
                    short_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {~disp_buf_q, idx_q};
                    wr_data_d = rx_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = StPend;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StPend: begin
                if (rx_valid) begin
                    overrun_err_d = 1'b1;
                end
                if (disp_frame_end) begin
                    disp_buf_d    = ~disp_buf_q;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            disp_buf_q    <= 1'b0;
            short_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            disp_buf_q    <= disp_buf_d;
            short_err_q   <= short_err_d;
            overrun_err_q <= overrun_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign disp_buf    = disp_buf_q;
    assign load_busy   = (state_q != StIdle);
    assign frame_ready = (state_q == StPend);
    assign short_err   = short_err_q;
    assign overrun_err = overrun_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Self-checking bench for frame_load_ctrl using a small frame (4x2 LEDs, 24 bytes).
module tb_frame_load_ctrl;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int AW   = 5;
    localparam int FB   = COLS * ROWS * 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cs_n = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          disp_frame_end = 1'b0;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [7:0]    wr_data;
    logic          disp_buf;
    logic          load_busy;
    logic          frame_ready;
    logic          short_err;
    logic          overrun_err;
    logic [7:0]    frame_count;

    frame_load_ctrl #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (AW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .cs_n           (cs_n),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .disp_frame_end (disp_frame_end),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .disp_buf       (disp_buf),
        .load_busy      (load_busy),
        .frame_ready    (frame_ready),
        .short_err      (short_err),
        .overrun_err    (overrun_err),
        .frame_count    (frame_count)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a transfer is "active" from the cycle cs_n is seen low while idle;
    // it has a count of accepted bytes; it is pending once that count reaches FB.
    bit m_active = 0;
    int m_n      = 0;
    int e_wr_en  = 0;
    int e_addr   = 0;
    int e_data   = 0;
    int e_disp   = 0;
    int e_cnt    = 0;
    int e_short  = 0;
    int e_ovr    = 0;

    // Observations used by the directed tests.
    int wr_total    = 0;
    int short_total = 0;
    int ovr_total   = 0;
    int q_addr[$];

    always @(posedge CLK) begin
        if (RST) begin
            m_active = 0; m_n = 0;
            e_wr_en = 0; e_addr = 0; e_data = 0; e_disp = 0; e_cnt = 0;
            e_short = 0; e_ovr = 0;
        end else begin
            e_wr_en = 0; e_short = 0; e_ovr = 0;
            if (!m_active) begin
                if (!cs_n) begin
                    m_active = 1;
                    m_n = 0;
                end
            end else if (m_n < FB) begin
                if (cs_n) begin
                    e_short = 1;
                    m_active = 0;
                end else if (rx_valid) begin
                    e_wr_en = 1;
                    e_addr  = (1 - e_disp) * (1 << AW) + m_n;
                    e_data  = int'(rx_data);
                    m_n++;
                end
            end else begin
                if (rx_valid) e_ovr = 1;
                if (disp_frame_end) begin
                    e_disp = 1 - e_disp;
                    e_cnt = (e_cnt + 1) % 256;
                    m_active = 0;
                end
            end
        end
        #1;
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        if (e_wr_en != 0) begin
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
        end
        chk("disp_buf", 32'(disp_buf), 32'(e_disp));
        chk("frame_count", 32'(frame_count), 32'(e_cnt));
        chk("load_busy", 32'(load_busy), 32'(m_active));
        chk("frame_ready", 32'(frame_ready), 32'(m_active && m_n == FB));
        chk("short_err", 32'(short_err), 32'(e_short));
        chk("overrun_err", 32'(overrun_err), 32'(e_ovr));
        if (wr_en) begin
            wr_total++;
            q_addr.push_back(int'(wr_addr));
        end
        if (short_err) short_total++;
        if (overrun_err) ovr_total++;
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic send(input int gap_max);
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        tick();
        rx_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) tick();
    endtask

    task automatic start_xfer();
        cs_n = 1'b0;
        tick();
    endtask

    task automatic pulse_fe();
        disp_frame_end = 1'b1;
        tick();
        disp_frame_end = 1'b0;
        tick();
    endtask

    task automatic full_frame_swap(input int gap_max);
        start_xfer();
        repeat (FB) send(gap_max);
        cs_n = 1'b1;
        pulse_fe();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base;
        int w0;
        int len;
        repeat (3) tick();
        RST = 1'b0;
        chk("reset disp_buf", 32'(disp_buf), 32'd0);
        chk("reset frame_count", 32'(frame_count), 32'd0);

        // Test 1: first frame goes to buffer 1, swap shows it.
        base = q_addr.size();
        start_xfer();
        repeat (FB) send(2);
        chk("t1 frame_ready", 32'(frame_ready), 32'd1);
        chk("t1 first addr", 32'(q_addr[base]), 32'h20);
        chk("t1 last addr", 32'(q_addr[base + FB - 1]), 32'h37);
        cs_n = 1'b1;
        pulse_fe();
        chk("t1 disp_buf", 32'(disp_buf), 32'd1);
        chk("t1 frame_count", 32'(frame_count), 32'd1);

        // Test 2: second frame goes to buffer 0.
        base = q_addr.size();
        full_frame_swap(1);
        chk("t2 first addr", 32'(q_addr[base]), 32'h00);
        chk("t2 last addr", 32'(q_addr[base + FB - 1]), 32'h17);
        chk("t2 disp_buf", 32'(disp_buf), 32'd0);
        chk("t2 frame_count", 32'(frame_count), 32'd2);

        // Test 3: short transfer, then a fresh frame restarts at index 0.
        w0 = short_total;
        start_xfer();
        repeat (10) send(1);
        cs_n = 1'b1;
        repeat (3) tick();
        chk("t3 short pulses", 32'(short_total - w0), 32'd1);
        chk("t3 disp_buf", 32'(disp_buf), 32'd0);
        base = q_addr.size();
        full_frame_swap(0);
        chk("t3 restart addr", 32'(q_addr[base]), 32'h20);

        // Test 4: one byte too many gives exactly FB writes and one overrun.
        w0 = wr_total;
        base = ovr_total;
        start_xfer();
        repeat (FB + 1) send(1);
        chk("t4 writes", 32'(wr_total - w0), 32'(FB));
        chk("t4 overruns", 32'(ovr_total - base), 32'd1);
        cs_n = 1'b1;
        pulse_fe();

        // Test 5: frame end during load is ignored.
        start_xfer();
        repeat (5) send(0);
        pulse_fe();
        chk("t5 no swap disp", 32'(disp_buf), 32'd0);
        chk("t5 no swap count", 32'(frame_count), 32'd4);
        repeat (FB - 5) send(0);
        cs_n = 1'b1;
        pulse_fe();
        chk("t5 swap disp", 32'(disp_buf), 32'd1);
        chk("t5 swap count", 32'(frame_count), 32'd5);

        // Randomised transfers: short, exact and overrunning, with stray frame-end pulses.
        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(FB + 3, 0);
            if ($urandom_range(1, 0) == 1) len = FB;
            start_xfer();
            for (int b = 0; b < len; b++) begin
                disp_frame_end = ($urandom_range(7, 0) == 0);
                send(2);
                disp_frame_end = 1'b0;
            end
            if (len < FB) begin
                cs_n = 1'b1;
                repeat (2) tick();
            end else begin
                repeat ($urandom_range(3, 0)) begin
                    cs_n = 1'($urandom);
                    rx_valid = 1'($urandom);
                    tick();
                end
                rx_valid = 1'b0;
                cs_n = 1'b1;
                pulse_fe();
            end
        end

        // Test 6: reset mid-load clears everything.
        start_xfer();
        repeat (12) send(0);
        RST = 1'b1;
        tick();
        chk("t6 wr_en", 32'(wr_en), 32'd0);
        chk("t6 wr_addr", 32'(wr_addr), 32'd0);
        chk("t6 wr_data", 32'(wr_data), 32'd0);
        chk("t6 disp_buf", 32'(disp_buf), 32'd0);
        chk("t6 load_busy", 32'(load_busy), 32'd0);
        chk("t6 frame_ready", 32'(frame_ready), 32'd0);
        chk("t6 frame_count", 32'(frame_count), 32'd0);
        cs_n = 1'b1;
        RST = 1'b0;
        tick();
        base = q_addr.size();
        full_frame_swap(0);
        chk("t6 restart addr", 32'(q_addr[base]), 32'h20);
        chk("t6 frame_count", 32'(frame_count), 32'd1);

        // Test 7: frame_count wraps after 256 swaps.
        repeat (254) full_frame_swap(0);
        chk("t7 count 255", 32'(frame_count), 32'd255);
        full_frame_swap(0);
        chk("t7 count wrap", 32'(frame_count), 32'd0);
        chk("t7 disp_buf", 32'(disp_buf), 32'd0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
